ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as LED set (0xED), reset (0xFF) or enable (0xF4), to the keyboard over the shared open-drain ps2_clk/ps2_data lines. It sits beside the keyboard receiver in the input path and runs on the receiver's system clock. The top level converts its drive-low enables into tri-states: the pin is driven 0 when the enable is 1, else 'z'.

## Interface
- CLK_FREQ_HZ, 100_000_000, pclk frequency; all cycle counts derive from it.
- INHIBIT_US, 120, time ps2_clk is held low before the start bit (≥100 µs per protocol).
- START_TIMEOUT_US, 15_000, maximum wait from clock release to the first device falling edge.
- FRAME_TIMEOUT_US, 2_000, maximum time from the first falling edge to the ack edge.

Ports (clock and reset first):
- pclk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous reset, active-high.
- tx_data  in  8  command byte, LSB sent first.
- tx_valid  in  1  request; the byte is accepted on a cycle where tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE; the receiver ignores line activity while busy.
- done  out  1  one-cycle pulse: the device acknowledged.
- err  out  1  one-cycle pulse: timeout or missing ack.
- ps2_clk_in  in  1  raw pin level, asynchronous.
- ps2_data_in  in  1  raw pin level, asynchronous.
- ps2_clk_oe  out  1  1 = pull ps2_clk low.
- ps2_data_oe  out  1  1 = pull ps2_data low.

## Operation
- Inputs pass through a 2-flop synchronizer. A falling edge (fall) is registered when the synced value is 0 and the previous synced value is 1.
- Shift register holds {parity, tx_data}. Parity is odd: ~^tx_data.
- IDLE: clk_oe=0, data_oe=0. On accept, latch the byte and parity, clear the counters, go to INHIBIT.
- INHIBIT: clk_oe=1. After INHIBIT_CYCLES, assert data_oe=1 (start bit) in the same cycle clk_oe drops to 0. Go to START.
- START: data_oe=1, wait for fall. On fall, drive bit0 (data_oe = ~bit), bit_cnt=1, go to XFER. START_TIMEOUT elapsing gives err and goes to IDLE.
- XFER: on each fall, shift out the next bit. Falls 2..8 drive bits 1..7 and fall 9 drives parity. Fall 10 releases data (data_oe=0, stop bit) and goes to ACK.
- ACK: on fall 11, sample synced ps2_data. A 0 goes to WAIT_IDLE; a 1 gives err and goes to IDLE.
- WAIT_IDLE: wait until synced clk=1 and data=1, then pulse done and go to IDLE.
- FRAME_TIMEOUT runs from entry to XFER until done. Expiry gives err, releases both lines and goes to IDLE.
- tx_valid is ignored while busy. done and err are mutually exclusive per request.
- Reset mid-frame: both oe go 0 on the reset edge, state goes to IDLE, and no done or err pulse is issued.

## Timing
- Reset values: state IDLE, tx_ready=1, busy=0, done=0, err=0, ps2_clk_oe=0, ps2_data_oe=0, counters 0.
- Accept at edge N; ps2_clk_oe=1 and busy=1 from N+1.
- INHIBIT_CYCLES = CLK_FREQ_HZ/1_000_000*INHIBIT_US: 12_000 at 100 MHz, so clk_oe is high for exactly 12_000 cycles.
- Pin fall to data_oe change: 3 pclk (2 sync + 1 edge register). This is negligible against the ~30 µs PS/2 half-period.
- done or err fires exactly one cycle. tx_ready returns the cycle after the pulse.
- Counter widths use $clog2 of the largest cycle count. START_TIMEOUT at 100 MHz is 1_500_000 cycles, which needs 21 bits; no wrap is possible.

## Structure
- Shared package ps2_pkg holds:
  - state encoding: IDLE, INHIBIT, START, XFER, ACK, WAIT_IDLE;
  - FRAME_BITS=11;
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4;
  - us-to-cycles helper.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detect for one line. It is reused by the keyboard receiver.
- Expected size: ~200 lines of RTL.

## Test plan
- Device model, tx_data=8'hED: clk_oe held exactly 12_000 cycles at 100 MHz. Bits observed at successive device rising edges are 0 (start), then 1,0,1,1,0,1,1,1, then parity 1, then stop 1. The model acks with 0 and done pulses once.
- tx_data=8'hF4: parity bit observed is 0 and done pulses.
- Model never clocks after release: err pulses 1_500_000 cycles after clk_oe falls, both oe are 0, and tx_ready returns to 1.
- Model clocks 11 edges but leaves data high at edge 11: err pulses and done never asserts.
- rst asserted after bit 4 of 8'hFF: oe=0 the next cycle, state IDLE, no done or err; a following 8'h00 transfer completes with parity 1.
- tx_valid held high while busy: exactly one transfer occurs, and a second byte is accepted only after done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length, common keyboard
// commands and a microseconds-to-clock-cycles helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    XFER,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int unsigned FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one asynchronous PS/2 line plus falling-edge
// detect on the synchronized level. Idle level of the bus is high.
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level  = r_sync;
  assign o_fall_c = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte
// with odd parity clocked by the device, and checks the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15_000,
  parameter int unsigned FRAME_TIMEOUT_US = 2_000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned START_CYCLES   = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
  localparam int unsigned FRAME_CYCLES   = us_to_cycles(CLK_FREQ_HZ, FRAME_TIMEOUT_US);
  localparam int unsigned MAX_A          = (INHIBIT_CYCLES > START_CYCLES) ?
                                           INHIBIT_CYCLES : START_CYCLES;
  localparam int unsigned MAX_CYCLES     = (MAX_A > FRAME_CYCLES) ? MAX_A : FRAME_CYCLES;
  localparam int unsigned CNT_W          = $clog2(MAX_CYCLES + 1);
  localparam int unsigned BIT_W          = $clog2(FRAME_BITS);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [8:0]         r_shift;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_clk_oe;
  logic               r_data_oe;

  logic w_clk_lvl;
  logic w_clk_fall;
  logic w_data_lvl;
  logic w_unused_data_fall;

  ps2_sync_edge u_clk_sync (
    .i_clk   (pclk),
    .i_rst   (rst),
    .i_line  (ps2_clk_in),
    .o_level (w_clk_lvl),
    .o_fall_c(w_clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .i_clk   (pclk),
    .i_rst   (rst),
    .i_line  (ps2_data_in),
    .o_level (w_data_lvl),
    .o_fall_c(w_unused_data_fall)
  );

  // r_cnt times the inhibit, then the start wait, then the whole device-clocked frame
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_valid && r_ready) begin
            r_shift   <= {~^tx_data, tx_data};
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            r_state   <= INHIBIT;
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        INHIBIT: begin
          if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            r_cnt     <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b1;
            r_state   <= START;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        START: begin
          if (w_clk_fall) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[8:1]};
            r_bit_cnt <= BIT_W'(1);
            r_cnt     <= '0;
            r_state   <= XFER;
          end else if (r_cnt == CNT_W'(START_CYCLES - 1)) begin
            r_err     <= 1'b1;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          // XFER, ACK and WAIT_IDLE all share the frame timeout
          if (r_cnt == CNT_W'(FRAME_CYCLES - 1)) begin
            r_err     <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
              XFER: begin
                if (w_clk_fall) begin
                  r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  if (r_bit_cnt == BIT_W'(FRAME_BITS - 2)) begin
                    r_data_oe <= 1'b0;
                    r_state   <= ACK;
                  end else begin
                    r_data_oe <= ~r_shift[0];
                    r_shift   <= {1'b0, r_shift[8:1]};
                  end
                end
              end
              ACK: begin
                if (w_clk_fall) begin
                  if (!w_data_lvl) begin
                    r_state <= WAIT_IDLE;
                  end else begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                  end
                end
              end
              default: begin
                if (w_clk_lvl && w_data_lvl) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx_ready    = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard drives the open-drain bus and
// frames are compared against an arithmetic model of the PS/2 frame.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ  = 10_000_000;
  localparam int unsigned INH_US  = 120;
  localparam int unsigned ST_US   = 300;
  localparam int unsigned FR_US   = 100;
  localparam int unsigned INH_CYC = CLK_HZ / 1_000_000 * INH_US;
  localparam int unsigned ST_CYC  = CLK_HZ / 1_000_000 * ST_US;
  localparam int          H       = 20;

  logic       pclk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk, dev_data, dev_abort;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int n_errp = 0;
  int n_acc = 0;
  int dev_falls = 0;
  bit prev_done = 1'b0;
  bit prev_err = 1'b0;

  always #5 pclk = ~pclk;

  // open-drain wired-AND of host and device
  assign ps2_clk_in  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data_in = ps2_data_oe ? 1'b0 : dev_data;

  ps2_host_tx #(
    .CLK_FREQ_HZ     (CLK_HZ),
    .INHIBIT_US      (INH_US),
    .START_TIMEOUT_US(ST_US),
    .FRAME_TIMEOUT_US(FR_US)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic request(input string tag, input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 50) begin @(negedge pclk); t++; end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    chk({tag, "_accept_clk_oe"}, 64'(ps2_clk_oe), 64'(1));
    chk({tag, "_accept_busy"}, 64'(busy), 64'(1));
  endtask

  // keyboard: measure inhibit, then clock 11 bits sampling data before each fall
  task automatic device(input bit do_clock, input bit ack,
                        output logic [10:0] bits, output int inh);
    int t = 0;
    bits = '1;
    inh  = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge pclk); t++; end
    while (ps2_clk_oe && inh < int'(4 * INH_CYC)) begin inh++; @(negedge pclk); end
    chk("start_bit_drive", 64'(ps2_data_oe), 64'(1));
    if (do_clock) begin
      for (int k = 0; k < 11; k++) begin
        repeat (H) @(negedge pclk);
        if (dev_abort) break;
        bits[k] = ps2_data_in;
        if (k == 10 && ack) begin
          dev_data = 1'b0;
          repeat (4) @(negedge pclk);
        end
        dev_clk = 1'b0;
        dev_falls++;
        repeat (H) @(negedge pclk);
        dev_clk = 1'b1;
      end
      repeat (H / 2) @(negedge pclk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_pulse(input string tag, input int d0, input int e0);
    int t = 0;
    while (n_done == d0 && n_errp == e0 && t < 300) begin @(negedge pclk); t++; end
    chk({tag, "_pulse_timeout"}, 64'(t < 300), 64'(1));
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] b, input bit ack,
                          output logic [10:0] bits);
    int d0, e0, inh;
    d0 = n_done;
    e0 = n_errp;
    request(tag, b);
    device(1'b1, ack, bits, inh);
    chk({tag, "_inhibit_len"}, 64'(inh), 64'(INH_CYC));
    chk({tag, "_bits"}, 64'(bits), 64'(model_frame(b)));
    wait_pulse(tag, d0, e0);
    if (ack) begin
      @(negedge pclk);
      chk({tag, "_ready_after_done"}, 64'(tx_ready), 64'(1));
    end
    repeat (10) @(negedge pclk);
    chk({tag, "_done_count"}, 64'(n_done - d0), 64'(ack));
    chk({tag, "_err_count"}, 64'(n_errp - e0), 64'(!ack));
    chk({tag, "_lines_released"}, 64'({ps2_clk_oe, ps2_data_oe}), 64'(0));
  endtask

  initial begin
    logic [10:0] bits;
    logic [10:0] mf;
    logic [7:0]  rb;
    int d0, e0, a0, n, t, inh;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    dev_clk = 1'b1; dev_data = 1'b1; dev_abort = 1'b0;
    fork
      begin : monitor
        forever begin
          @(posedge pclk);
          if (!rst && tx_valid && tx_ready) n_acc++;
          #1;
          if (!rst) begin
            chk("busy_and_ready", 64'(busy & tx_ready), 64'(0));
            chk("lines_while_ready", 64'(tx_ready & (ps2_clk_oe | ps2_data_oe)), 64'(0));
            chk("done_err_exclusive", 64'(done & err), 64'(0));
            chk("pulse_one_cycle", 64'((done & prev_done) | (err & prev_err)), 64'(0));
            if (done) n_done++;
            if (err) n_errp++;
          end
          prev_done = done;
          prev_err  = err;
        end
      end
      begin : watchdog
        repeat (200_000) @(posedge pclk);
        n_err++;
        $display("FAIL watchdog: bench did not complete within cycle budget");
      end
      begin : main
        repeat (3) @(negedge pclk);
        chk("rst_ready", 64'(tx_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pulses", 64'({done, err}), 64'(0));
        chk("rst_oe", 64'({ps2_clk_oe, ps2_data_oe}), 64'(0));
        rst = 1'b0;
        @(negedge pclk);

        mf = model_frame(CMD_SET_LED);
        chk("model_frame_ED", 64'(mf), 64'(11'b11111011010));
        mf = model_frame(CMD_ENABLE);
        chk("model_parity_F4", 64'(mf[9]), 64'(0));
        mf = model_frame(8'h00);
        chk("model_parity_00", 64'(mf[9]), 64'(1));
        mf = model_frame(CMD_RESET);
        chk("model_parity_FF", 64'(mf[9]), 64'(1));

        run_xfer("ed", CMD_SET_LED, 1'b1, bits);
        run_xfer("f4", CMD_ENABLE, 1'b1, bits);
        chk("f4_parity_seen", 64'(bits[9]), 64'(0));
        for (int i = 0; i < 4; i++) begin
          rb = 8'($urandom);
          run_xfer("rand", rb, 1'b1, bits);
        end

        // device never clocks: start timeout
        d0 = n_done; e0 = n_errp;
        request("tmo", 8'($urandom));
        device(1'b0, 1'b0, bits, inh);
        chk("tmo_inhibit_len", 64'(inh), 64'(INH_CYC));
        n = 0;
        while (!err && n < int'(ST_CYC + 100)) begin
          @(posedge pclk); n++; @(negedge pclk);
        end
        chk("tmo_latency", 64'(n), 64'(ST_CYC));
        chk("tmo_oe", 64'({ps2_clk_oe, ps2_data_oe}), 64'(0));
        @(negedge pclk);
        chk("tmo_ready_back", 64'(tx_ready), 64'(1));
        repeat (5) @(negedge pclk);
        chk("tmo_err_count", 64'(n_errp - e0), 64'(1));
        chk("tmo_no_done", 64'(n_done - d0), 64'(0));

        rb = 8'($urandom);
        run_xfer("nack", rb, 1'b0, bits);

        // reset in the middle of 8'hFF, after bit 4 has been driven
        d0 = n_done; e0 = n_errp;
        request("rstmid", CMD_RESET);
        fork
          device(1'b1, 1'b1, bits, inh);
          begin
            n = dev_falls;
            t = 0;
            while (dev_falls < n + 5 && t < 2000) begin @(negedge pclk); t++; end
            chk("rstmid_reach_bit4", 64'(t < 2000), 64'(1));
            repeat (H / 2) @(negedge pclk);
            rst = 1'b1;
            @(negedge pclk);
            chk("rstmid_oe", 64'({ps2_clk_oe, ps2_data_oe}), 64'(0));
            chk("rstmid_idle", 64'({tx_ready, busy}), 64'(2'b10));
            rst = 1'b0;
            dev_abort = 1'b1;
          end
        join
        dev_abort = 1'b0;
        repeat (50) @(negedge pclk);
        chk("rstmid_no_pulse", 64'((n_done - d0) + (n_errp - e0)), 64'(0));
        run_xfer("zero", 8'h00, 1'b1, bits);
        chk("zero_parity_seen", 64'(bits[9]), 64'(1));

        // tx_valid held high across a whole transfer
        a0 = n_acc; d0 = n_done; e0 = n_errp;
        tx_data  = CMD_ENABLE;
        tx_valid = 1'b1;
        device(1'b1, 1'b1, bits, inh);
        chk("held_a_bits", 64'(bits), 64'(model_frame(CMD_ENABLE)));
        wait_pulse("held_a", d0, e0);
        chk("held_single_accept", 64'(n_acc - a0), 64'(1));
        tx_data = CMD_SET_LED;
        t = 0;
        while (!busy && t < 20) begin @(negedge pclk); t++; end
        tx_valid = 1'b0;
        chk("held_second_accept", 64'(n_acc - a0), 64'(2));
        device(1'b1, 1'b1, bits, inh);
        chk("held_b_inhibit_len", 64'(inh), 64'(INH_CYC));
        chk("held_b_bits", 64'(bits), 64'(model_frame(CMD_SET_LED)));
        wait_pulse("held_b", d0 + 1, e0);
        repeat (10) @(negedge pclk);
        chk("held_done_count", 64'(n_done - d0), 64'(2));
        chk("held_err_count", 64'(n_errp - e0), 64'(0));
        chk("held_accepts_final", 64'(n_acc - a0), 64'(2));
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
